fetch_pc_unit: RTL and testbench

Front-end PC generator and instruction fetch unit for the RV64 core. It consumes the redirect produced by the branch/jump resolution unit (redirect strobe plus target PC). It issues sequential fetch requests to instruction memory over a valid/ready handshake, buffers in-order responses, and presents {instruction, PC} to decode over a valid/ready handshake. On a redirect it squashes buffered and in-flight fetches.

---
 rtl/fetch_pc_unit_pkg.sv | 21 ++
 rtl/fetch_ibuf.sv | 66 ++++++
 rtl/fetch_pc_unit.sv | 110 +++++++++++
 tb/tb_fetch_pc_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch front end.
// Provides the instruction width, the sequential PC step, the default reset PC,
// the instruction-buffer entry layout and a PC alignment helper.
package fetch_pc_unit_pkg;

  localparam int          INSTR_WIDTH      = 32;
  localparam logic [63:0] PC_STEP          = 64'd4;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  // One buffered fetch: the instruction and the PC it was fetched from.
  typedef struct packed {
    logic [63:0]            pc;
    logic [INSTR_WIDTH-1:0] instr;
  } ibuf_entry_t;

  // Instructions are 4-byte aligned; any low-bit set means an illegal target.
  function automatic logic is_misaligned(input logic [63:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ibuf.sv
// Instruction buffer: synchronous FIFO of {pc, instr} entries.
// Ports:
//   clk_in, rst_in    clock and synchronous active-high reset
//   push, push_data   write an entry at the tail
//   pop               remove the head entry (ignored when empty)
//   flush             drop every entry; overrides push and pop that cycle
//   head              current head entry (valid when !empty)
//   count, full, empty  occupancy status
module fetch_ibuf
  import fetch_pc_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          push,
  input  ibuf_entry_t   push_data,
  input  logic          pop,
  input  logic          flush,
  output ibuf_entry_t   head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  ibuf_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push & ~flush & (~full | do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers decide validity,
  // so stale contents are never observed and the array maps to plain RAM/flops.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_pc_unit.sv
// Front-end PC generator and instruction fetch unit.
// Issues sequential fetches to instruction memory under a credit limit,
// buffers in-order responses and hands {instr, pc} to decode. A redirect
// squashes buffered and in-flight fetches; a misaligned target halts fetch.
// Ports:
//   clk_in, rst_in                     clock, synchronous active-high reset
//   imem_req_valid/ready/addr          fetch request handshake
//   imem_resp_valid_in/data_in         in-order fetch responses
//   redirect_signal_in/pc_in           taken branch / jump from resolution
//   instr_valid/ready, instr/instr_pc  decode handshake and payload
//   misaligned_signal_out              halted on a misaligned redirect target
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IBUF_DEPTH = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  output logic                   imem_req_valid_out,
  input  logic                   imem_req_ready_in,
  output logic [63:0]            imem_req_addr_out,
  input  logic                   imem_resp_valid_in,
  input  logic [INSTR_WIDTH-1:0] imem_resp_data_in,
  input  logic                   redirect_signal_in,
  input  logic [63:0]            redirect_pc_in,
  output logic                   instr_valid_out,
  input  logic                   instr_ready_in,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [63:0]            instr_pc_out,
  output logic                   misaligned_signal_out
);

  localparam int          CW           = $clog2(IBUF_DEPTH) + 1;
  localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(IBUF_DEPTH);

  logic [63:0]   pc_reg;
  logic [63:0]   resp_pc;
  logic [CW-1:0] outstanding_cnt;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] ibuf_count;
  logic          misaligned;
  logic          ibuf_full;
  logic          ibuf_empty;
  ibuf_entry_t   ibuf_head;
  ibuf_entry_t   resp_entry;
  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          resp_keep;
  logic          pop;

  // Every accepted request owns a buffer slot until it is popped or squashed,
  // so responses can never find the buffer full.
  assign credit_used        = {1'b0, outstanding_cnt} + {1'b0, ibuf_count};
  assign imem_req_valid_out = ~misaligned & ~redirect_signal_in & (credit_used < CREDIT_LIMIT);
  assign imem_req_addr_out  = pc_reg;
  assign req_fire           = imem_req_valid_out & imem_req_ready_in;

  // Responses belonging to squashed requests are counted out by discard_cnt.
  assign resp_keep  = imem_resp_valid_in & ~redirect_signal_in & (discard_cnt == '0);
  assign pop        = instr_valid_out & instr_ready_in;
  assign resp_entry = '{pc: resp_pc, instr: imem_resp_data_in};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_reg          <= RESET_PC;
      resp_pc         <= RESET_PC;
      outstanding_cnt <= '0;
      discard_cnt     <= '0;
      misaligned      <= 1'b0;
    end else begin
      outstanding_cnt <= outstanding_cnt + CW'(req_fire) - CW'(imem_resp_valid_in);
      if (redirect_signal_in) begin
        // Everything still in flight after this edge belongs to the old path.
        discard_cnt <= outstanding_cnt - CW'(imem_resp_valid_in);
        pc_reg      <= redirect_pc_in;
        resp_pc     <= redirect_pc_in;
        misaligned  <= is_misaligned(redirect_pc_in);
      end else begin
        if (imem_resp_valid_in && (discard_cnt != '0)) discard_cnt <= discard_cnt - CW'(1);
        if (req_fire)  pc_reg  <= pc_reg + PC_STEP;
        if (resp_keep) resp_pc <= resp_pc + PC_STEP;
      end
    end
  end

  fetch_ibuf #(
    .DEPTH(IBUF_DEPTH)
  ) u_ibuf (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (resp_keep),
    .push_data(resp_entry),
    .pop      (pop),
    .flush    (redirect_signal_in),
    .head     (ibuf_head),
    .count    (ibuf_count),
    .full     (ibuf_full),
    .empty    (ibuf_empty)
  );

  assign instr_valid_out       = ~ibuf_empty;
  assign instr_out             = ibuf_head.instr;
  assign instr_pc_out          = ibuf_head.pc;
  assign misaligned_signal_out = misaligned;

  resp_slot_a: assert property (@(posedge clk_in) disable iff (rst_in)
    imem_resp_valid_in |-> !ibuf_full);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios with literal
// expectations followed by randomized traffic against a queue-based model.
module tb_fetch_pc_unit;

  localparam logic [63:0] RST_PC = 64'h1000;
  localparam int          DEPTH  = 2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        imem_req_valid_out;
  logic        imem_req_ready_in;
  logic [63:0] imem_req_addr_out;
  logic        imem_resp_valid_in;
  logic [31:0] imem_resp_data_in;
  logic        redirect_signal_in;
  logic [63:0] redirect_pc_in;
  logic        instr_valid_out;
  logic        instr_ready_in;
  logic [31:0] instr_out;
  logic [63:0] instr_pc_out;
  logic        misaligned_signal_out;

  int total = 0;
  int bad   = 0;

  fetch_pc_unit #(.RESET_PC(RST_PC), .IBUF_DEPTH(DEPTH)) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .imem_req_valid_out   (imem_req_valid_out),
    .imem_req_ready_in    (imem_req_ready_in),
    .imem_req_addr_out    (imem_req_addr_out),
    .imem_resp_valid_in   (imem_resp_valid_in),
    .imem_resp_data_in    (imem_resp_data_in),
    .redirect_signal_in   (redirect_signal_in),
    .redirect_pc_in       (redirect_pc_in),
    .instr_valid_out      (instr_valid_out),
    .instr_ready_in       (instr_ready_in),
    .instr_out            (instr_out),
    .instr_pc_out         (instr_pc_out),
    .misaligned_signal_out(misaligned_signal_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // In-flight requests remember their own PC and whether a redirect has
  // orphaned them; the buffer is a plain queue of delivered instructions.
  typedef struct { logic [63:0] pc; bit keep; } flight_t;
  typedef struct { logic [31:0] instr; logic [63:0] pc; } slot_t;

  flight_t     inflight[$];
  slot_t       ibufq[$];
  logic [63:0] m_pc;
  bit          m_mis;
  bit          m_init = 1'b0;

  function automatic bit m_req_valid();
    return !m_mis && !redirect_signal_in && (inflight.size() + ibufq.size() < DEPTH);
  endfunction

  always @(posedge clk_in) begin
    bit      fire;
    flight_t f;
    if (rst_in) begin
      inflight.delete();
      ibufq.delete();
      m_pc   = RST_PC;
      m_mis  = 1'b0;
      m_init = 1'b1;
    end else if (m_init) begin
      fire = m_req_valid() && imem_req_ready_in;
      if (!redirect_signal_in && instr_ready_in && ibufq.size() > 0) void'(ibufq.pop_front());
      if (imem_resp_valid_in && inflight.size() > 0) begin
        f = inflight.pop_front();
        if (f.keep && !redirect_signal_in) ibufq.push_back('{imem_resp_data_in, f.pc});
      end
      if (redirect_signal_in) begin
        ibufq.delete();
        foreach (inflight[i]) inflight[i].keep = 1'b0;
        m_pc  = redirect_pc_in;
        m_mis = (redirect_pc_in[1:0] != 2'b00);
      end else if (fire) begin
        inflight.push_back('{m_pc, 1'b1});
        m_pc = m_pc + 64'd4;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_in) begin
    #2;
    if (m_init && !rst_in) begin
      check("req_valid", imem_req_valid_out, m_req_valid());
      if (m_req_valid()) check("req_addr", imem_req_addr_out, m_pc);
      check("instr_valid", instr_valid_out, ibufq.size() > 0);
      if (ibufq.size() > 0) begin
        check("instr", instr_out, ibufq[0].instr);
        check("instr_pc", instr_pc_out, ibufq[0].pc);
      end
      check("misaligned", misaligned_signal_out, m_mis);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic rdr, input logic [63:0] rpc, input logic rv,
                       input logic [31:0] rd, input logic rq, input logic ir);
    @(negedge clk_in);
    rst_in             = 1'b0;
    redirect_signal_in = rdr;
    redirect_pc_in     = rpc;
    imem_resp_valid_in = rv;
    imem_resp_data_in  = rd;
    imem_req_ready_in  = rq;
    instr_ready_in     = ir;
    #1;
  endtask

  initial begin
    rst_in             = 1'b1;
    redirect_signal_in = 1'b0;
    redirect_pc_in     = '0;
    imem_resp_valid_in = 1'b0;
    imem_resp_data_in  = '0;
    imem_req_ready_in  = 1'b0;
    instr_ready_in     = 1'b0;
    repeat (2) @(posedge clk_in);

    // Sequential requests until credits run out.
    drive(0, 0, 0, 0, 1, 0);
    check("rst_req_valid", imem_req_valid_out, 1);
    check("rst_addr", imem_req_addr_out, 64'h1000);
    check("rst_instr_valid", instr_valid_out, 0);
    check("rst_misaligned", misaligned_signal_out, 0);
    drive(0, 0, 0, 0, 1, 0);
    check("seq_addr", imem_req_addr_out, 64'h1004);
    drive(0, 0, 0, 0, 1, 0);
    check("credit_stall", imem_req_valid_out, 0);

    // First response, no bypass, then pop frees a credit.
    drive(0, 0, 1, 32'h00500093, 1, 1);
    check("no_bypass", instr_valid_out, 0);
    drive(0, 0, 0, 0, 1, 1);
    check("first_valid", instr_valid_out, 1);
    check("first_instr", instr_out, 32'h00500093);
    check("first_pc", instr_pc_out, 64'h1000);
    drive(0, 0, 1, 32'h11111111, 1, 0);
    check("resume_addr", imem_req_addr_out, 64'h1008);

    // Two buffered responses hold off requests until decode drains them.
    drive(0, 0, 1, 32'h22222222, 1, 0);
    check("full_stall0", imem_req_valid_out, 0);
    drive(0, 0, 0, 0, 1, 0);
    check("full_stall1", imem_req_valid_out, 0);
    check("head_pc_1004", instr_pc_out, 64'h1004);
    drive(0, 0, 0, 0, 1, 1);
    check("head_instr_1004", instr_out, 32'h11111111);
    drive(0, 0, 0, 0, 1, 1);
    check("head_pc_1008", instr_pc_out, 64'h1008);
    check("head_instr_1008", instr_out, 32'h22222222);
    check("resume_100c", imem_req_addr_out, 64'h100C);
    drive(0, 0, 0, 0, 1, 1);
    check("addr_1010", imem_req_addr_out, 64'h1010);

    // Redirect with two requests in flight.
    drive(1, 64'h2000, 0, 0, 1, 1);
    check("redirect_no_req", imem_req_valid_out, 0);
    drive(0, 0, 1, 32'hDEAD0001, 1, 1);
    check("flushed", instr_valid_out, 0);
    drive(0, 0, 1, 32'hDEAD0002, 1, 1);
    check("redir_addr", imem_req_addr_out, 64'h2000);
    drive(0, 0, 1, 32'h00A00113, 0, 1);
    check("dropped_both", instr_valid_out, 0);
    drive(0, 0, 0, 0, 1, 1);
    check("redir_pc", instr_pc_out, 64'h2000);
    check("redir_instr", instr_out, 32'h00A00113);

    // Redirect coinciding with a response, one more still in flight.
    drive(0, 0, 0, 0, 1, 1);
    check("addr_2008", imem_req_addr_out, 64'h2008);
    drive(1, 64'h3000, 1, 32'hDEAD0003, 1, 1);
    drive(0, 0, 1, 32'hDEAD0004, 0, 1);
    check("same_cycle_drop", instr_valid_out, 0);
    check("addr_3000", imem_req_addr_out, 64'h3000);
    drive(0, 0, 0, 0, 1, 1);
    check("discard_drop", instr_valid_out, 0);
    drive(0, 0, 1, 32'h00108093, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    check("pc_3000", instr_pc_out, 64'h3000);
    check("instr_3000", instr_out, 32'h00108093);

    // Misaligned redirect halts fetch until an aligned redirect.
    drive(1, 64'h2002, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    check("mis_set", misaligned_signal_out, 1);
    check("mis_no_req", imem_req_valid_out, 0);
    check("mis_flush", instr_valid_out, 0);
    drive(0, 0, 0, 0, 1, 1);
    check("mis_hold", imem_req_valid_out, 0);
    drive(1, 64'h4000, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    check("mis_clear", misaligned_signal_out, 0);
    check("addr_4000", imem_req_addr_out, 64'h4000);

    // PC wraps silently past the top of the address space.
    drive(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1, 1);
    drive(0, 0, 1, 32'hDEAD0005, 1, 1);
    check("addr_top", imem_req_addr_out, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(0, 0, 0, 0, 1, 1);
    check("addr_wrap", imem_req_addr_out, 64'h0);

    // Randomized traffic, with one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] rpc;
      int          sel;
      sel = $urandom_range(0, 7);
      rpc = {$urandom, $urandom};
      if (sel == 0)      rpc = 64'hFFFF_FFFF_FFFF_FFF0 | (rpc & 64'hC);
      else if (sel != 1) rpc = rpc & ~64'h3;
      if (rpc[1:0] == 2'b00 && sel == 1) rpc[0] = 1'b1;
      @(negedge clk_in);
      rst_in             = (i == 1500);
      redirect_signal_in = ($urandom_range(0, 19) == 0);
      redirect_pc_in     = rpc;
      imem_resp_valid_in = !rst_in && inflight.size() > 0 && ($urandom_range(0, 2) != 0);
      imem_resp_data_in  = $urandom;
      imem_req_ready_in  = ($urandom_range(0, 3) != 0);
      instr_ready_in     = ($urandom_range(0, 2) != 0);
    end

    @(negedge clk_in);
    rst_in             = 1'b0;
    redirect_signal_in = 1'b0;
    imem_resp_valid_in = 1'b0;
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
